// File: rtl/flat_stream_pkg.sv
// Shared types and helpers for the flat-vector stream bridge.
// Beat counts are derived with a ceiling division so padded widths work.
package flat_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    SEND   = 2'd3
  } state_t;

  function automatic int beats(input int width, input int beat_w);
    return (width + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/flat_beat_shreg.sv
// MSB-first beat shift register: parallel load (zero-padded at the top),
// shift by one beat per enable, and a beat counter that wraps after the last beat.
module flat_beat_shreg
  import flat_stream_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int BEAT_W = 4,
  localparam int NBEATS = beats(WIDTH, BEAT_W),
  localparam int TOTAL  = NBEATS * BEAT_W,
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              shift,
  input  logic [BEAT_W-1:0] shift_in,
  output logic [TOTAL-1:0]  data,
  output logic [TOTAL-1:0]  next_data,
  output logic [BEAT_W-1:0] top_beat,
  output logic [CW-1:0]     count,
  output logic              at_last
);

  logic [TOTAL+BEAT_W-1:0] shifted_ext;

  // next_data is the register contents after the pending shift, visible
  // combinationally so a caller can capture the full word on the last beat.
  assign shifted_ext = {data, shift_in};
  assign next_data   = shifted_ext[TOTAL-1:0];
  assign top_beat    = data[TOTAL-1 -: BEAT_W];
  assign at_last     = (count == CW'(NBEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= TOTAL'(load_data);
      count <= '0;
    end else if (shift) begin
      data  <= next_data;
      count <= at_last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/flat_stream_bridge.sv
// Deserializes input beats into a flat vector for a combinational wrapper,
// captures the wrapper result and serializes it back out as beats.
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never drops and data/last never change while waiting for ready.
module flat_stream_bridge
  import flat_stream_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 12,
  parameter int BEAT_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BEAT_W-1:0] s_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  vec_count,
  output logic              busy
);

  localparam int IN_BEATS  = beats(IN_W, BEAT_W);
  localparam int OUT_BEATS = beats(OUT_W, BEAT_W);
  localparam int IN_TOTAL  = IN_BEATS * BEAT_W;
  localparam int OUT_TOTAL = OUT_BEATS * BEAT_W;
  localparam int IN_CW     = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int OUT_CW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  state_t state;

  logic                 in_accept, in_last;
  logic                 out_accept, out_at_last;
  logic [IN_TOTAL-1:0]  in_data, in_next;
  logic [BEAT_W-1:0]    in_top;
  logic [IN_CW-1:0]     in_cnt;
  logic [OUT_TOTAL-1:0] out_data, out_next;
  logic [OUT_CW-1:0]    out_cnt;
  logic                 unused_bits;

  assign s_ready    = (state == LOAD);
  assign busy       = (state != LOAD);
  assign in_accept  = s_valid && s_ready;
  assign out_accept = m_valid && m_ready;

  flat_beat_shreg #(.WIDTH(IN_W), .BEAT_W(BEAT_W)) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ('0),
    .shift     (in_accept),
    .shift_in  (s_data),
    .data      (in_data),
    .next_data (in_next),
    .top_beat  (in_top),
    .count     (in_cnt),
    .at_last   (in_last)
  );

  // The serializer loads at the end of SETTLE and shifts zeros in, so it
  // is empty again (m_data = 0) once the last beat has left.
  flat_beat_shreg #(.WIDTH(OUT_W), .BEAT_W(BEAT_W)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == SETTLE),
    .load_data (dut_out),
    .shift     (out_accept),
    .shift_in  ('0),
    .data      (out_data),
    .next_data (out_next),
    .top_beat  (m_data),
    .count     (out_cnt),
    .at_last   (out_at_last)
  );

  assign unused_bits = ^{in_data, in_top, in_cnt, in_next, out_data, out_next, out_at_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dut_in    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      vec_count <= '0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          if (in_accept && in_last) begin
            dut_in <= in_next[IN_W-1:0];
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          vec_count <= vec_count + CNT_W'(1);
          m_valid   <= 1'b1;
          m_last    <= (OUT_BEATS == 1);
          state     <= SEND;
        end
        SEND: begin
          if (out_accept) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= LOAD;
            end else begin
              m_last <= (int'(out_cnt) == OUT_BEATS - 2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
